demux_tdm_1bit: RTL and testbench
=================================

DEMUX_TDM_1BIT -- requirements
Module: demux_tdm_1bit

Interface
REQ-001 SHALL have parameter OUTS, default 16, number of 1-bit output channels; legal range 2..256, need not be a power of 2.
REQ-002 SHALL derive localparam SW = $clog2(OUTS) as the channel-index width.
REQ-003 SHALL have port clk, input, 1, single rising-edge clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port din, input, 1, serial time-division data bit.
REQ-006 SHALL have port din_valid, input, 1, din qualifier; no bit is consumed when low.
REQ-007 SHALL have port sync, input, 1, frame marker; meaningful only with din_valid high, and marks that din belongs to channel 0.
REQ-008 SHALL have port f, output, OUTS, registered parallel frame; f[k] = last completed bit of channel k.
REQ-009 SHALL have port frame_valid, output, 1, one-cycle pulse after f updates.
REQ-010 SHALL have port ch, output, SW, channel index the next valid bit will be written to.
REQ-011 SHALL have port locked, output, 1, high in state LOCK.
REQ-012 SHALL have port sync_err, output, 1, one-cycle pulse on misaligned sync.

Function
REQ-013 SHALL implement two states, HUNT and LOCK, plus an internal OUTS-bit work register and an index counter.
REQ-014 In HUNT, valid bits with sync low SHALL be discarded, leaving ch at 0 and f unchanged.
REQ-015 In HUNT, a valid bit with sync high SHALL be written to work[0], set ch to 1, and move to LOCK on the same edge.
REQ-016 In LOCK, each valid bit SHALL be written to work[ch], and ch SHALL then increment.
REQ-017 ch SHALL wrap from OUTS-1 to 0; values >= OUTS SHALL never occur, including for non-power-of-2 OUTS.
REQ-018 On the edge capturing channel OUTS-1, f SHALL load the complete frame (work with bit OUTS-1 = din) and frame_valid SHALL be high for the following cycle only.
REQ-019 Latency SHALL be one clock from the last bit of a frame to f/frame_valid.
REQ-020 In LOCK, a valid sync with ch = 0 SHALL be accepted as normal alignment, with no error.
REQ-021 In LOCK, a valid sync with ch != 0 SHALL: discard the partial frame, write din to work[0], set ch to 1, pulse sync_err for one cycle, leave f unchanged, and suppress frame_valid.
REQ-022 sync with din_valid low SHALL be ignored in both states.
REQ-023 With din_valid low, work, ch, f and state SHALL hold, and frame_valid and sync_err SHALL be 0.
REQ-024 f SHALL hold its value between frames; channels never glitch mid-frame.

Reset
REQ-025 Asserting reset SHALL immediately force: state HUNT, ch = 0, work = 0, f = 0, frame_valid = 0, sync_err = 0, locked = 0.
REQ-026 Reset mid-frame SHALL abandon the partial frame with no frame_valid pulse.
REQ-027 The first frame after reset release SHALL require a sync (see REQ-033).

Configuration
REQ-028 Macro DEMUX_TDM_HUNT_EN SHALL select the framing behaviour.
REQ-029 With DEMUX_TDM_HUNT_EN defined, the block SHALL behave per REQ-013..REQ-027.
REQ-030 With DEMUX_TDM_HUNT_EN undefined, there SHALL be no HUNT state.
REQ-031 With DEMUX_TDM_HUNT_EN undefined, reset SHALL enter LOCK with locked = 1 and ch = 0, and the first valid bit SHALL go to channel 0 with or without sync.
REQ-032 With DEMUX_TDM_HUNT_EN undefined, REQ-020..REQ-022 SHALL still apply.
REQ-033 With DEMUX_TDM_HUNT_EN undefined, REQ-027 SHALL not apply.

Verification
REQ-034 Bench SHALL cover: OUTS=16, HUNT_EN, sync then 16 contiguous valid bits 0xA5C3 (ch0 = LSB) -> f = 16'hA5C3 one cycle after bit 15, frame_valid high exactly 1 cycle, locked = 1.
REQ-035 Bench SHALL cover: OUTS=5, 3 frames back to back, bits 5'b10110 each, sync only on first -> ch sequence 0..4 wraps to 0 (never 5..7), 3 frame_valid pulses, f = 5'b10110.
REQ-036 Bench SHALL cover: OUTS=16, din_valid toggling 50% randomly during a frame of 0x1234 -> f = 16'h1234, bits consumed only on valid cycles, frame_valid only after 16th valid bit.
REQ-037 Bench SHALL cover: OUTS=16, sync at ch = 7 in LOCK -> sync_err pulse 1 cycle, ch = 1 next cycle, no frame_valid, f unchanged; the following 15 bits complete a new frame.
REQ-038 Bench SHALL cover: OUTS=16, HUNT_EN, 20 valid bits without sync -> ch stays 0, locked = 0, f = 0, no pulses.
REQ-039 Bench SHALL cover: OUTS=16, reset asserted asynchronously at ch = 9 -> all outputs 0 before the next clk edge, state HUNT; without macro, locked = 1 and the first bit after release lands in f[0].

Source files
------------

// File: rtl/demux_tdm_1bit_if.sv
// ============================================================================
// Module   : demux_tdm_1bit_if
// Brief    : Bus bundle for the 1-bit TDM demultiplexer (serial in, frame out).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface demux_tdm_1bit_if #(
  parameter int OUTS = 16
) ();
  localparam int SW = $clog2(OUTS);

  logic            din;
  logic            din_valid;
  logic            sync;
  logic [OUTS-1:0] f;
  logic            frame_valid;
  logic [SW-1:0]   ch;
  logic            locked;
  logic            sync_err;

  modport master (
    output din, din_valid, sync,
    input  f, frame_valid, ch, locked, sync_err
  );

  modport slave (
    input  din, din_valid, sync,
    output f, frame_valid, ch, locked, sync_err
  );
endinterface

`default_nettype wire

// File: rtl/demux_tdm_1bit.sv
// ============================================================================
// Module   : demux_tdm_1bit
// Brief    : Serial 1-bit TDM stream to OUTS-wide parallel frame. Optional
//            sync hunting is enabled by defining DEMUX_TDM_HUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_tdm_1bit #(
  parameter int OUTS = 16
) (
  input  logic                clk,
  input  logic                reset,
  demux_tdm_1bit_if.slave     bus
);

  localparam int SW = $clog2(OUTS);

  localparam logic [0:0]    HUNT    = 1'b0;
  localparam logic [0:0]    LOCK    = 1'b1;
  localparam logic [SW-1:0] LAST_CH = SW'(OUTS - 1);

`ifdef DEMUX_TDM_HUNT_EN
  localparam bit         HUNT_EN   = 1'b1;
  localparam logic [0:0] RST_STATE = HUNT;
`else
  localparam bit         HUNT_EN   = 1'b0;
  localparam logic [0:0] RST_STATE = LOCK;
`endif

  logic [0:0]      state_q, state_d;
  logic [OUTS-1:0] work_q,  work_d;
  logic [OUTS-1:0] f_q,     f_d;
  logic [SW-1:0]   ch_q,    ch_d;
  logic            fv_q,    fv_d;
  logic            se_q,    se_d;

  logic            hunting;
  logic            realign;

  assign hunting = HUNT_EN && (state_q == HUNT);
  // Sync at channel 0 while locked is ordinary alignment, not a restart.
  assign realign = bus.sync && (hunting || (ch_q != '0));

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    f_d     = f_q;
    ch_d    = ch_q;
    fv_d    = 1'b0;
    se_d    = 1'b0;
    if (bus.din_valid) begin
      if (realign) begin
        work_d    = '0;
        work_d[0] = bus.din;
        ch_d      = SW'(1);
        state_d   = LOCK;
        se_d      = !hunting;
      end else if (!hunting) begin
        for (int k = 0; k < OUTS; k++) begin
          if (ch_q == SW'(k)) begin
            work_d[k] = bus.din;
          end
        end
        if (ch_q == LAST_CH) begin
          f_d         = work_q;
          f_d[OUTS-1] = bus.din;
          fv_d        = 1'b1;
          ch_d        = '0;
        end else begin
          ch_d = ch_q + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST_STATE;
      work_q  <= '0;
      f_q     <= '0;
      ch_q    <= '0;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      f_q     <= f_d;
      ch_q    <= ch_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
    end
  end

  assign bus.f           = f_q;
  assign bus.frame_valid = fv_q;
  assign bus.ch          = ch_q;
  assign bus.locked      = (state_q == LOCK);
  assign bus.sync_err    = se_q;

endmodule

`default_nettype wire

// File: tb/tb_demux_tdm_1bit.sv
// ============================================================================
// Module   : tb_demux_tdm_1bit
// Brief    : Scoreboard bench for demux_tdm_1bit (OUTS=16 and OUTS=5 instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_tdm_1bit;

  typedef struct {
    logic        is_err;
    logic [15:0] val;
  } ev_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  ev_t  q16[$];
  ev_t  q5[$];
  ev_t  e16;
  ev_t  e5;

`ifdef DEMUX_TDM_HUNT_EN
  localparam logic RST_LOCKED = 1'b0;
`else
  localparam logic RST_LOCKED = 1'b1;
`endif

  demux_tdm_1bit_if #(.OUTS(16)) b16 ();
  demux_tdm_1bit_if #(.OUTS(5))  b5  ();

  demux_tdm_1bit #(.OUTS(16)) u16 (.clk(clk), .reset(reset), .bus(b16));
  demux_tdm_1bit #(.OUTS(5))  u5  (.clk(clk), .reset(reset), .bus(b5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push16(input logic is_err, input logic [15:0] val);
    ev_t e;
    e.is_err = is_err;
    e.val    = val;
    q16.push_back(e);
  endtask

  task automatic drv16(input logic d, input logic v, input logic s);
    b16.din       = d;
    b16.din_valid = v;
    b16.sync      = s;
    @(posedge clk);
    #1;
    b16.din_valid = 1'b0;
    b16.sync      = 1'b0;
  endtask

  task automatic drv5(input logic d, input logic v, input logic s);
    b5.din       = d;
    b5.din_valid = v;
    b5.sync      = s;
    @(posedge clk);
    #1;
    b5.din_valid = 1'b0;
    b5.sync      = 1'b0;
  endtask

  // Scoreboard monitors: every pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (b16.frame_valid || b16.sync_err) begin
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL mon16_unexpected: got fv=%b se=%b f=%h expected no pulse",
                 b16.frame_valid, b16.sync_err, b16.f);
      end else begin
        e16 = q16.pop_front();
        if (e16.is_err ? !(b16.sync_err && !b16.frame_valid)
                       : !(b16.frame_valid && !b16.sync_err && b16.f == e16.val)) begin
          errors++;
          $display("FAIL mon16_event: got fv=%b se=%b f=%h expected err=%b f=%h",
                   b16.frame_valid, b16.sync_err, b16.f, e16.is_err, e16.val);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b5.frame_valid || b5.sync_err) begin
      checks++;
      if (q5.size() == 0) begin
        errors++;
        $display("FAIL mon5_unexpected: got fv=%b se=%b f=%b expected no pulse",
                 b5.frame_valid, b5.sync_err, b5.f);
      end else begin
        e5 = q5.pop_front();
        if (e5.is_err ? !(b5.sync_err && !b5.frame_valid)
                      : !(b5.frame_valid && !b5.sync_err && 16'(b5.f) == e5.val)) begin
          errors++;
          $display("FAIL mon5_event: got fv=%b se=%b f=%b expected err=%b f=%h",
                   b5.frame_valid, b5.sync_err, b5.f, e5.is_err, e5.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    logic [4:0]  p5;
    int          idx;
    int          cyc;
    ev_t         e;

    checks = 0;
    errors = 0;
    b16.din = 0; b16.din_valid = 0; b16.sync = 0;
    b5.din  = 0; b5.din_valid  = 0; b5.sync  = 0;
    reset = 1'b1;
    #1;
    chk("rst_f",      32'(b16.f), 32'h0);
    chk("rst_fv",     32'(b16.frame_valid), 32'h0);
    chk("rst_se",     32'(b16.sync_err), 32'h0);
    chk("rst_ch",     32'(b16.ch), 32'h0);
    chk("rst_locked", 32'(b16.locked), 32'(RST_LOCKED));
    @(posedge clk);
    #1;
    reset = 1'b0;
    drv16(0, 0, 0);

`ifdef DEMUX_TDM_HUNT_EN
    // 20 valid bits with no sync are all discarded while hunting.
    for (int i = 0; i < 20; i++) begin
      drv16(1'($urandom), 1'b1, 1'b0);
      chk("hunt_ch", 32'(b16.ch), 32'h0);
      chk("hunt_locked", 32'(b16.locked), 32'h0);
    end
    chk("hunt_f", 32'(b16.f), 32'h0);
`endif

    // Frame 0xA5C3, channel 0 first, sync on bit 0.
    w = 16'hA5C3;
    push16(1'b0, w);
    for (int i = 0; i < 16; i++) begin
      drv16(w[i], 1'b1, i == 0);
      if (i < 15) chk("a5_fv_early", 32'(b16.frame_valid), 32'h0);
    end
    chk("a5_f", 32'(b16.f), 32'hA5C3);
    chk("a5_fv", 32'(b16.frame_valid), 32'h1);
    chk("a5_locked", 32'(b16.locked), 32'h1);
    chk("a5_ch", 32'(b16.ch), 32'h0);
    drv16(0, 0, 0);
    chk("a5_fv_drop", 32'(b16.frame_valid), 32'h0);
    chk("a5_f_hold", 32'(b16.f), 32'hA5C3);

    // Frame 0x1234 with din_valid randomly gated; invalid cycles carry noise.
    w = 16'h1234;
    push16(1'b0, w);
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 400) begin
      cyc++;
      if ($urandom_range(0, 1) == 1) begin
        drv16(w[idx], 1'b1, idx == 0);
        idx++;
      end else begin
        drv16(1'($urandom), 1'b0, 1'($urandom));
      end
      chk("g_ch", 32'(b16.ch), 32'(idx % 16));
      if (idx < 16) chk("g_fv", 32'(b16.frame_valid), 32'h0);
    end
    chk("g_done", 32'(idx), 32'd16);
    chk("g_f", 32'(b16.f), 32'h1234);
    drv16(0, 0, 0);

    // Sync arriving at ch=7 restarts the frame and flags an error.
    w = 16'h5555;
    for (int i = 0; i < 7; i++) drv16(w[i], 1'b1, i == 0);
    chk("se_pre_ch", 32'(b16.ch), 32'h7);
    w = 16'hBEEF;
    push16(1'b1, 16'h0);
    push16(1'b0, w);
    drv16(w[0], 1'b1, 1'b1);
    chk("se_pulse", 32'(b16.sync_err), 32'h1);
    chk("se_ch", 32'(b16.ch), 32'h1);
    chk("se_fv", 32'(b16.frame_valid), 32'h0);
    chk("se_f", 32'(b16.f), 32'h1234);
    drv16(0, 0, 0);
    chk("se_drop", 32'(b16.sync_err), 32'h0);
    for (int i = 1; i < 16; i++) drv16(w[i], 1'b1, 1'b0);
    chk("se_new_f", 32'(b16.f), 32'hBEEF);
    drv16(0, 0, 0);

    // Asynchronous reset mid-frame at ch=9.
    w = 16'h0F0F;
    for (int i = 0; i < 9; i++) drv16(w[i], 1'b1, i == 0);
    chk("ar_pre_ch", 32'(b16.ch), 32'h9);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_f", 32'(b16.f), 32'h0);
    chk("ar_fv", 32'(b16.frame_valid), 32'h0);
    chk("ar_se", 32'(b16.sync_err), 32'h0);
    chk("ar_ch", 32'(b16.ch), 32'h0);
    chk("ar_locked", 32'(b16.locked), 32'(RST_LOCKED));
    @(posedge clk);
    #1;
    reset = 1'b0;
`ifdef DEMUX_TDM_HUNT_EN
    drv16(1'b1, 1'b1, 1'b0);
    chk("ar_hunt_ch", 32'(b16.ch), 32'h0);
    chk("ar_hunt_locked", 32'(b16.locked), 32'h0);
    w = 16'h00F1;
    push16(1'b0, w);
    for (int i = 0; i < 16; i++) drv16(w[i], 1'b1, i == 0);
    chk("ar_relock_f", 32'(b16.f), 32'h00F1);
`else
    w = 16'h0001;
    push16(1'b0, w);
    for (int i = 0; i < 16; i++) drv16(w[i], 1'b1, 1'b0);
    chk("ar_f0", 32'(b16.f[0]), 32'h1);
    chk("ar_nosync_f", 32'(b16.f), 32'h0001);
`endif
    drv16(0, 0, 0);

    // OUTS=5: three back-to-back frames, sync only on the very first bit.
    p5 = 5'b10110;
    e.is_err = 1'b0;
    e.val    = 16'(p5);
    for (int fr = 0; fr < 3; fr++) q5.push_back(e);
    for (int fr = 0; fr < 3; fr++) begin
      for (int i = 0; i < 5; i++) begin
        drv5(p5[i], 1'b1, (fr == 0) && (i == 0));
        chk("o5_ch", 32'(b5.ch), 32'((i + 1) % 5));
      end
      chk("o5_f", 32'(b5.f), 32'(p5));
    end
    drv5(0, 0, 0);
    chk("o5_locked", 32'(b5.locked), 32'h1);

    repeat (3) @(posedge clk);
    #1;
    chk("q16_empty", 32'(q16.size()), 32'h0);
    chk("q5_empty", 32'(q5.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
